// File: rtl/rotary_input_decoder_if.sv
// Encoder pin and event bundle between the rotary front end and the LED controller.
// master = decoder side (consumes raw pins, drives events); slave = the opposite end.
interface rotary_input_decoder_if;
  logic enc_a;
  logic enc_b;
  logic enc_sw;
  logic rot_up;
  logic rot_dn;
  logic push;
  logic push_long;
  logic quad_err;

  modport master (
    input  enc_a, enc_b, enc_sw,
    output rot_up, rot_dn, push, push_long, quad_err
  );

  modport slave (
    output enc_a, enc_b, enc_sw,
    input  rot_up, rot_dn, push, push_long, quad_err
  );
endinterface

// File: rtl/rotary_input_decoder.sv
// Rotary encoder front end: synchronize + debounce A/B/switch, quadrature decode with detent accumulator.
// Define PUSH_LONG_EN to build the long-press detector; otherwise push_long is tied to 0.
module rotary_input_decoder #(
  parameter int DEBOUNCE_CYCLES   = 40000,
  parameter int STEPS_PER_DETENT  = 4,
  parameter int LONG_PRESS_CYCLES = 40000000
) (
  input  logic                          clk,
  input  logic                          res,
  rotary_input_decoder_if.master        bus
);

  localparam int                      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]        DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0]       STEP_POS = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0]       STEP_NEG = -STEP_POS;

  if (DEBOUNCE_CYCLES < 1 ||
      !(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4) ||
      LONG_PRESS_CYCLES < 1) begin : g_bad_params
    $error("rotary_input_decoder: illegal parameter value");
  end

  // Pin index: 0 = A, 1 = B, 2 = switch (active-low)
  logic [2:0]       pins;
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic [1:0]        q;
  logic [1:0]        prev_q, prev_d;
  logic signed [3:0] acc_q, acc_d;
  logic signed [3:0] acc_inc, acc_dec;
  logic              sw_prev_q, sw_prev_d;
  logic              rot_up_q, rot_up_d;
  logic              rot_dn_q, rot_dn_d;
  logic              push_q, push_d;
  logic              quad_err_q, quad_err_d;

  assign pins    = {bus.enc_sw, bus.enc_b, bus.enc_a};
  assign q       = {stable_q[0], stable_q[1]};
  assign acc_inc = acc_q + 4'sd1;
  assign acc_dec = acc_q - 4'sd1;

  // Position of a state along the clockwise cycle 11 -> 01 -> 00 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    case (s)
      2'b11:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b00:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  always_comb begin
    sync1_d  = pins;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    prev_d     = prev_q;
    acc_d      = acc_q;
    rot_up_d   = 1'b0;
    rot_dn_d   = 1'b0;
    quad_err_d = 1'b0;
    sw_prev_d  = stable_q[2];
    push_d     = sw_prev_q & ~stable_q[2];
    if (q != prev_q) begin
      prev_d = q;
      if ((q ^ prev_q) == 2'b11) begin
        quad_err_d = 1'b1;
        acc_d      = '0;
      end else if (gray_pos(q) == gray_pos(prev_q) + 2'd1) begin
        if (acc_inc == STEP_POS) begin
          rot_up_d = 1'b1;
          acc_d    = '0;
        end else begin
          acc_d = acc_inc;
        end
      end else begin
        if (acc_dec == STEP_NEG) begin
          rot_dn_d = 1'b1;
          acc_d    = '0;
        end else begin
          acc_d = acc_dec;
        end
      end
      // Landing on the detent without an event realigns the accumulator.
      if (q == 2'b11 && !rot_up_d && !rot_dn_d) acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      stable_q   <= '1;
      cnt_q      <= '{default: '0};
      prev_q     <= 2'b11;
      acc_q      <= '0;
      sw_prev_q  <= 1'b1;
      rot_up_q   <= 1'b0;
      rot_dn_q   <= 1'b0;
      push_q     <= 1'b0;
      quad_err_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      sw_prev_q  <= sw_prev_d;
      rot_up_q   <= rot_up_d;
      rot_dn_q   <= rot_dn_d;
      push_q     <= push_d;
      quad_err_q <= quad_err_d;
    end
  end

  assign bus.rot_up   = rot_up_q;
  assign bus.rot_dn   = rot_dn_q;
  assign bus.push     = push_q;
  assign bus.quad_err = quad_err_q;

`ifdef PUSH_LONG_EN
  localparam int                HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              push_long_q, push_long_d;

  // Counter saturates at HOLD_MAX so the long-press pulse fires once per hold.
  always_comb begin
    hold_d      = '0;
    push_long_d = 1'b0;
    if (!stable_q[2]) begin
      hold_d = hold_q;
      if (hold_q != HOLD_MAX) begin
        hold_d      = hold_q + HOLD_W'(1);
        push_long_d = (hold_d == HOLD_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      hold_q      <= '0;
      push_long_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      push_long_q <= push_long_d;
    end
  end

  assign bus.push_long = push_long_q;
`else
  assign bus.push_long = 1'b0;
`endif

endmodule

// File: tb/tb_rotary_input_decoder.sv
// Directed bench for rotary_input_decoder with DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4, LONG_PRESS_CYCLES=100.
module tb_rotary_input_decoder;
  localparam int DEB   = 4;
  localparam int STEPS = 4;
  localparam int LONG  = 100;
  localparam int LAT   = DEB + 3;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   cyc = 0;

  rotary_input_decoder_if bus ();

  rotary_input_decoder #(
    .DEBOUNCE_CYCLES  (DEB),
    .STEPS_PER_DETENT (STEPS),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vectors = 0;
  int n_miscompares = 0;

  int n_up = 0, n_dn = 0, n_push = 0, n_long = 0, n_err = 0, n_wide = 0;
  int last_up = -1, last_dn = -1, last_push = -1, last_long = -1, last_err = -1;
  logic [4:0] outs, prev_outs = '0;

  // Pulse monitor sampling on the falling edge, away from the register updates.
  always @(negedge clk) begin
    outs = {bus.rot_up, bus.rot_dn, bus.push, bus.push_long, bus.quad_err};
    if (bus.rot_up)    begin n_up++;   last_up   = cyc; end
    if (bus.rot_dn)    begin n_dn++;   last_dn   = cyc; end
    if (bus.push)      begin n_push++; last_push = cyc; end
    if (bus.push_long) begin n_long++; last_long = cyc; end
    if (bus.quad_err)  begin n_err++;  last_err  = cyc; end
    if ((outs & prev_outs) != 5'b0) n_wide++;
    prev_outs = outs;
  end

  int b_up, b_dn, b_push, b_long, b_err;
  int set_cyc;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_vectors++;
    if (observed != expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic markWindow();
    b_up = n_up; b_dn = n_dn; b_push = n_push; b_long = n_long; b_err = n_err;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic sw, input int hold);
    bus.enc_a  = a;
    bus.enc_b  = b;
    bus.enc_sw = sw;
    set_cyc    = cyc;
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    int final_set;
    bus.enc_a  = 1'b1;
    bus.enc_b  = 1'b1;
    bus.enc_sw = 1'b1;
    res        = 1'b1;

    // Reset and idle
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", int'({bus.rot_up, bus.rot_dn, bus.push, bus.push_long, bus.quad_err}), 0);
    res = 1'b0;
    markWindow();
    repeat (50) @(negedge clk);
    checkOutput("idle_events", (n_up - b_up) + (n_dn - b_dn) + (n_push - b_push) +
                               (n_long - b_long) + (n_err - b_err), 0);

    // One clockwise detent
    markWindow();
    applyStimulus(0, 1, 1, 10);
    applyStimulus(0, 0, 1, 10);
    applyStimulus(1, 0, 1, 10);
    applyStimulus(1, 1, 1, 10);
    final_set = set_cyc;
    checkOutput("cw_up_count", n_up - b_up, 1);
    checkOutput("cw_up_cycle", last_up, final_set + LAT);
    checkOutput("cw_dn_count", n_dn - b_dn, 0);
    checkOutput("cw_err_count", n_err - b_err, 0);

    // Two counter-clockwise detents back to back
    markWindow();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 1, 10);
      applyStimulus(0, 0, 1, 10);
      applyStimulus(0, 1, 1, 10);
      applyStimulus(1, 1, 1, 10);
    end
    final_set = set_cyc;
    checkOutput("ccw_dn_count", n_dn - b_dn, 2);
    checkOutput("ccw_dn_cycle", last_dn, final_set + LAT);
    checkOutput("ccw_up_count", n_up - b_up, 0);

    // Bouncing switch, then steady press and release
    markWindow();
    for (int k = 0; k < 10; k++) applyStimulus(1, 1, (k % 2 == 0) ? 1'b0 : 1'b1, 2);
    checkOutput("bounce_no_push", n_push - b_push, 0);
    applyStimulus(1, 1, 0, 30);
    final_set = set_cyc;
    checkOutput("press_push_count", n_push - b_push, 1);
    checkOutput("press_push_cycle", last_push, final_set + LAT);
    applyStimulus(1, 1, 1, 20);
    checkOutput("release_no_push", n_push - b_push, 1);
    checkOutput("short_hold_no_long", n_long - b_long, 0);

    // Short glitch on A
    markWindow();
    applyStimulus(0, 1, 1, 3);
    applyStimulus(1, 1, 1, 20);
    checkOutput("glitch_events", (n_up - b_up) + (n_dn - b_dn) + (n_err - b_err), 0);

    // Half turn and back, then a full clockwise detent
    markWindow();
    applyStimulus(0, 1, 1, 10);
    applyStimulus(0, 0, 1, 10);
    applyStimulus(0, 1, 1, 10);
    applyStimulus(1, 1, 1, 10);
    checkOutput("half_turn_rot", (n_up - b_up) + (n_dn - b_dn), 0);
    applyStimulus(0, 1, 1, 10);
    applyStimulus(0, 0, 1, 10);
    applyStimulus(1, 0, 1, 10);
    applyStimulus(1, 1, 1, 10);
    checkOutput("after_half_up", n_up - b_up, 1);
    checkOutput("after_half_dn", n_dn - b_dn, 0);

    // Illegal jump 11 -> 00, then legal walk back to the detent
    markWindow();
    applyStimulus(0, 0, 1, 10);
    final_set = set_cyc;
    checkOutput("illegal_err_count", n_err - b_err, 1);
    checkOutput("illegal_err_cycle", last_err, final_set + LAT);
    applyStimulus(1, 0, 1, 10);
    applyStimulus(1, 1, 1, 10);
    checkOutput("illegal_err_total", n_err - b_err, 1);
    checkOutput("illegal_rot", (n_up - b_up) + (n_dn - b_dn), 0);

    // Long press
    markWindow();
    applyStimulus(1, 1, 0, 150);
    final_set = set_cyc;
    applyStimulus(1, 1, 1, 20);
    checkOutput("long_push_count", n_push - b_push, 1);
    checkOutput("long_push_cycle", last_push, final_set + LAT);
`ifdef PUSH_LONG_EN
    checkOutput("long_pulse_count", n_long - b_long, 1);
    checkOutput("long_pulse_cycle", last_long, final_set + DEB + 2 + LONG);
`else
    checkOutput("long_pulse_count", n_long - b_long, 0);
`endif

    // Pins held at A/B=00, switch pressed through a reset
    markWindow();
    res = 1'b1;
    applyStimulus(0, 0, 0, 3);
    checkOutput("midreset_outputs", int'({bus.rot_up, bus.rot_dn, bus.push, bus.push_long, bus.quad_err}), 0);
    res = 1'b0;
    final_set = cyc;
    repeat (20) @(negedge clk);
    checkOutput("midreset_push_count", n_push - b_push, 1);
    checkOutput("midreset_push_cycle", last_push, final_set + LAT);
    checkOutput("midreset_err_count", n_err - b_err, 1);
    checkOutput("midreset_err_cycle", last_err, final_set + LAT);
    checkOutput("midreset_rot", (n_up - b_up) + (n_dn - b_dn), 0);

    res = 1'b1;
    applyStimulus(1, 1, 1, 3);
    res = 1'b0;
    repeat (10) @(negedge clk);

    checkOutput("pulse_width", n_wide, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/rotary_input_decoder.md
Name: rotary_input_decoder

Overview:
Front end for the rotary-encoder/WS2812B design. Takes the raw, asynchronous, bouncing encoder pins (A, B, push switch) and produces the clean single-cycle event pulses rot_up, rot_dn and push that the LED controller consumes. Each pin passes through a synchronizer and a debouncer. A quadrature state machine with a detent accumulator follows. The block runs on the 40 MHz system clock.

Parameters:
DEBOUNCE_CYCLES, 40000, clocks a synchronized input must differ from its stable value before the stable value changes (1 ms @ 40 MHz); legal range >= 1
STEPS_PER_DETENT, 4, quadrature steps per output event; legal values 1, 2, 4
LONG_PRESS_CYCLES, 40000000, clocks the debounced switch must stay pressed before push_long fires (used only with PUSH_LONG_EN)

Ports:
clk  input  1  system clock, 40 MHz, single clock domain
res  input  1  synchronous active-high reset
enc_a  input  1  raw encoder channel A, asynchronous, idle-high
enc_b  input  1  raw encoder channel B, asynchronous, idle-high
enc_sw  input  1  raw push switch, asynchronous, active-low (0 = pressed)
rot_up  output  1  one-cycle pulse per clockwise detent
rot_dn  output  1  one-cycle pulse per counter-clockwise detent
push  output  1  one-cycle pulse per debounced press
push_long  output  1  one-cycle pulse on long press; constant 0 without PUSH_LONG_EN
quad_err  output  1  one-cycle pulse on an illegal quadrature transition

Behaviour:
- Reset (res=1 at a clk edge):
  - sync FFs and stable values to 1; debounce counters to 0
  - previous quad state to 2'b11; accumulator to 0
  - all outputs to 0
- Synchronizer: 2 FF stages per pin. Edge E0 is the first edge that samples the new pin value.
- Debounce, per pin:
  - If sync != stable: when cnt == DEBOUNCE_CYCLES-1, stable <= sync and cnt <= 0; otherwise cnt++.
  - If sync == stable: cnt <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - A pulse shorter than DEBOUNCE_CYCLES synchronized cycles never reaches stable.
- Latency: every output pulse is registered. It asserts at edge E(DEBOUNCE_CYCLES+2) and lasts exactly one cycle.
- Quadrature: state q = {A_stable, B_stable}, evaluated when q differs from the previous q.
  - Up step: 11→01, 01→00, 00→10, 10→11.
  - Down step: the reverse of each up step.
  - Illegal step (both bits change): quad_err pulse, acc <= 0, no rot pulse.
- Accumulator: signed, range -STEPS_PER_DETENT..+STEPS_PER_DETENT.
  - Up step: if acc+1 == STEPS_PER_DETENT, pulse rot_up and set acc <= 0; else acc++.
  - Down step: mirror of up step, pulsing rot_dn.
  - If the new q is 11 and no pulse was issued that cycle, acc <= 0 (detent resync).
  - A reversal mid-detent walks acc back toward 0.
- rot_up and rot_dn are mutually exclusive. push, push_long and quad_err are independent and may coincide with either.
- Push: pulse on the stable 1→0 transition of the switch. Release produces no pulse.
- Reset mid-operation: all state returns to reset values.
  - A switch held low through reset yields one push pulse at E(DEBOUNCE_CYCLES+2) after res falls.
  - A/B sitting at 00 through reset yields one quad_err and no rot pulse.

Optional Feature:
PUSH_LONG_EN
- Defined:
  - A hold counter of width $clog2(LONG_PRESS_CYCLES+1) counts while the stable switch is pressed.
  - When it reaches LONG_PRESS_CYCLES, push_long pulses once and the counter saturates.
  - The counter clears on release or reset.
  - push still pulses at press.
- Undefined: the counter logic is absent and push_long is tied to 0. The port list is unchanged.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4, LONG_PRESS_CYCLES=100, and each pin state is held 10 cycles unless stated.
1. Reset: res=1 for 3 cycles, pins=1 → all outputs 0; no pulses for 50 cycles after release.
2. CW sequence 11→01→00→10→11 → exactly one rot_up, width 1, at E6 after the final transition to 11; rot_dn=0 and quad_err=0 throughout.
3. CCW sequence 11→10→00→01→11 → exactly one rot_dn; a second CCW detent immediately after → a second rot_dn; rot_up=0.
4. Bounce: enc_sw toggles every 2 cycles for 20 cycles, then held 0 → exactly one push; a 3-cycle glitch on enc_a → no event.
5. Half turn then full turn: 11→01→00→01→11 → no pulse. A following full CW sequence → exactly one rot_up.
6. Illegal and long press:
   - A/B 11→00 directly → one quad_err, no rot pulse.
   - With PUSH_LONG_EN, enc_sw held 0 for 150 cycles → one push, then one push_long 100 cycles after the debounced press, then nothing more.
   - Without PUSH_LONG_EN, the same stimulus → push_long stays 0.
